cpu_regfile_ctx: RTL and testbench
==================================

Name: cpu_regfile_ctx

Overview:
Register file that sinks the write-back stage output (rf_wd) and supplies the operand read ports for the multi-cycle CPU. It also contains a context engine for interrupt entry and exit. On a save request it streams every register to a data-memory context area. On a restore request it streams the registers back from that area. The interrupt FSM drives the save and restore requests; dm_* connects to the data-memory port mux.

Parameters:
DW, 16, data/register width
AW, 3, register address width; NREG = 2**AW registers
CTX_BASE, 16'h00F0, data-memory word address of the context area (register i at CTX_BASE+i)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
rf_ra1  in  AW  read address, port 1
rf_ra2  in  AW  read address, port 2
rf_rd1  out  DW  read data, port 1
rf_rd2  out  DW  read data, port 2
rf_wa  in  AW  write address from write-back
rf_wd  in  DW  write data from write-back
rf_we  in  1  write enable from FSM
ctx_save  in  1  start context save (sampled in IDLE only)
ctx_restore  in  1  start context restore (sampled in IDLE only)
ctx_busy  out  1  context engine active
ctx_done  out  1  one-cycle completion pulse
dm_a  out  16  data-memory address
dm_id  out  DW  data-memory write data
dm_we  out  1  data-memory write enable
dm_od  in  DW  data-memory read data (asynchronous read, valid in the same cycle as dm_a)

Behaviour:
Reset and clocking
- One clock; reset is asynchronous and active-high.
- Asserting reset clears all NREG registers to 0 and forces state=IDLE and idx=0.
- Reset values of outputs: ctx_busy=0, ctx_done=0, dm_we=0, dm_a=0, dm_id=0.
- Reset mid-save or mid-restore aborts immediately. No further dm_we is issued, and memory is left partially written.

Register file
- rf_rd1 = reg[rf_ra1] and rf_rd2 = reg[rf_ra2], both combinational, in all states.
- Write: reg[rf_wa] <= rf_wd on the rising edge when rf_we=1 and state=IDLE.
- rf_we is ignored while ctx_busy=1 (the FSM must not write back during a context switch).
- Read of an address written in the same cycle returns the old value, unless the optional feature below is enabled.

Context engine FSM (states IDLE, SAVE, RESTORE, DONE; idx counter AW bits)
- IDLE:
  - ctx_save=1 -> SAVE, idx=0.
  - else ctx_restore=1 -> RESTORE, idx=0.
  - If both are asserted, save wins.
- SAVE:
  - ctx_busy=1, dm_we=1, dm_a=CTX_BASE+idx, dm_id=reg[idx] (combinational from idx).
  - idx increments each cycle.
  - When idx=NREG-1 -> DONE; no wrap or extra write.
- RESTORE:
  - ctx_busy=1, dm_we=0, dm_a=CTX_BASE+idx.
  - reg[idx] <= dm_od at the clock edge; idx increments.
  - When idx=NREG-1 -> DONE.
- DONE:
  - ctx_busy=0, ctx_done=1 for exactly one cycle, dm_a=0, dm_we=0 -> IDLE.
  - ctx_save/ctx_restore are not accepted in DONE.
- Latency: request in IDLE at edge k; memory accesses occupy cycles k+1 .. k+NREG; ctx_done is high in cycle k+NREG+1. With NREG=8, that is 8 access cycles plus 1 done cycle.
- ctx_save/ctx_restore asserted while busy or in DONE are ignored (not queued).
- dm_a address arithmetic is 16-bit modulo. CTX_BASE+NREG-1 past 16'hFFFF wraps; this is legal but not expected in practice.
- In IDLE: dm_a=0, dm_id=0, dm_we=0.

Optional Feature:
WB_BYPASS_EN
- Defined: write-to-read bypass is added. If rf_we=1, state=IDLE and rf_wa equals rf_ra1 (or rf_ra2), that read port returns rf_wd in the same cycle. The bypass is disabled while ctx_busy=1.
- Undefined: no bypass; reads return the pre-write register value.

Test Plan:
- Reset, then read all addresses -> rf_rd1=rf_rd2=0 for all 8 registers; dm_we=0, ctx_busy=0.
- Write reg3=16'hBEEF, reg5=16'h1234, then read ra1=3, ra2=5 -> rf_rd1=16'hBEEF, rf_rd2=16'h1234.
- Load reg i=16'hA000+i, pulse ctx_save -> 8 cycles with dm_we=1 and dm_a=16'h00F0..16'h00F7 / dm_id=16'hA000..16'hA007; then ctx_done pulses once; rf_we asserted during save has no effect.
- Clear registers, model memory with [00F0+i]=16'h5A00+i, pulse ctx_restore -> after ctx_done, reg i=16'h5A00+i; dm_we stays 0 throughout.
- Assert ctx_save and ctx_restore together -> save performed. Re-pulse ctx_save at the 3rd busy cycle -> ignored, only 8 writes. Assert reset in the 4th save cycle -> dm_we=0 immediately, registers read 0.
- Same-cycle write/read of reg2=16'h00FF -> old value without WB_BYPASS_EN; 16'h00FF with it.

Source files
------------

// File: rtl/cpu_regfile_ctx.sv
// cpu_regfile_ctx: register file with interrupt context save/restore engine.
// Ports: clock/reset (async, active-high); rf_ra1/rf_ra2 -> rf_rd1/rf_rd2 combinational reads;
// rf_wa/rf_wd/rf_we write-back port (IDLE only); ctx_save/ctx_restore requests, ctx_busy/ctx_done status;
// dm_a/dm_id/dm_we/dm_od data-memory port for the context area at CTX_BASE.
// Optional macro WB_BYPASS_EN adds same-cycle write-to-read forwarding.
module cpu_regfile_ctx #(
  parameter int DW = 16,
  parameter int AW = 3,
  parameter logic [15:0] CTX_BASE = 16'h00F0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] rf_ra1,
  input  logic [AW-1:0] rf_ra2,
  output logic [DW-1:0] rf_rd1,
  output logic [DW-1:0] rf_rd2,
  input  logic [AW-1:0] rf_wa,
  input  logic [DW-1:0] rf_wd,
  input  logic          rf_we,
  input  logic          ctx_save,
  input  logic          ctx_restore,
  output logic          ctx_busy,
  output logic          ctx_done,
  output logic [15:0]   dm_a,
  output logic [DW-1:0] dm_id,
  output logic          dm_we,
  input  logic [DW-1:0] dm_od
);
  localparam int NREG = 2 ** AW;
  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  logic [DW-1:0] regs [NREG];
  logic wr_ok;
  assign wr_ok = rf_we && state == IDLE;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      if (state == RESTORE) regs[idx] <= dm_od;
      else if (wr_ok) regs[rf_wa] <= rf_wd;
    end
  always_comb begin
    state_nx = state;
    idx_nx = '0;
    case (state)
      IDLE: state_nx = ctx_save ? SAVE : ctx_restore ? RESTORE : IDLE;
      SAVE, RESTORE: begin
        idx_nx = idx + 1'b1;
        if (idx == AW'(NREG - 1)) begin
          state_nx = DONE;
          idx_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  assign ctx_busy = state == SAVE || state == RESTORE;
  assign ctx_done = state == DONE;
  assign dm_we = state == SAVE;
  assign dm_a = ctx_busy ? CTX_BASE + 16'(idx) : 16'h0000;
  assign dm_id = state == SAVE ? regs[idx] : '0;
`ifdef WB_BYPASS_EN
  assign rf_rd1 = (wr_ok && rf_wa == rf_ra1) ? rf_wd : regs[rf_ra1];
  assign rf_rd2 = (wr_ok && rf_wa == rf_ra2) ? rf_wd : regs[rf_ra2];
`else
  assign rf_rd1 = regs[rf_ra1];
  assign rf_rd2 = regs[rf_ra2];
`endif
endmodule

// File: tb/tb_cpu_regfile_ctx.sv
// tb_cpu_regfile_ctx: scoreboard bench for the register file and context engine.
module tb_cpu_regfile_ctx;
  logic clock = 0, reset = 1;
  logic [2:0] rf_ra1 = 0, rf_ra2 = 0, rf_wa = 0;
  logic [15:0] rf_wd = 0, rf_rd1, rf_rd2, dm_a, dm_id, dm_od;
  logic rf_we = 0, ctx_save = 0, ctx_restore = 0, ctx_busy, ctx_done, dm_we;
  logic [15:0] mem [256];
  logic [31:0] q [$];
  int n_vec = 0, n_err = 0;
`ifdef WB_BYPASS_EN
  localparam logic [15:0] BYP_EXP = 16'h00FF;
`else
  localparam logic [15:0] BYP_EXP = 16'h0000;
`endif

  cpu_regfile_ctx dut (
    .clock(clock), .reset(reset), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we), .ctx_save(ctx_save), .ctx_restore(ctx_restore),
    .ctx_busy(ctx_busy), .ctx_done(ctx_done), .dm_a(dm_a), .dm_id(dm_id), .dm_we(dm_we), .dm_od(dm_od)
  );

  always #5 clock = ~clock;
  assign dm_od = mem[dm_a[7:0]];
  always @(posedge clock) if (dm_we) mem[dm_a[7:0]] <= dm_id;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    rf_we = 1; rf_wa = a; rf_wd = d;
    step;
    rf_we = 0;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    reset = 1;
    #1;
    for (int a = 0; a < 8; a++) begin
      rf_ra1 = 3'(a); rf_ra2 = 3'(7 - a);
      q.push_back({16'h0, 16'h0});
      #1;
      e = q.pop_front();
      n_vec++;
      if ({rf_rd1, rf_rd2} !== e) begin
        n_err++;
        $display("FAIL reset_read a=%0d got %h expected %h", a, {rf_rd1, rf_rd2}, e);
      end
    end
    n_vec++;
    if ({dm_we, ctx_busy, ctx_done, dm_a, dm_id} !== 35'h0) begin
      n_err++;
      $display("FAIL reset_outputs got we=%b busy=%b done=%b a=%h id=%h expected all 0", dm_we, ctx_busy, ctx_done, dm_a, dm_id);
    end
    @(posedge clock);
    #1 reset = 0;
  endtask

  task automatic test_write_read;
    logic [31:0] e;
    wr(3, 16'hBEEF);
    wr(5, 16'h1234);
    rf_ra1 = 3; rf_ra2 = 5;
    q.push_back({16'hBEEF, 16'h1234});
    #1;
    e = q.pop_front();
    n_vec++;
    if ({rf_rd1, rf_rd2} !== e) begin
      n_err++;
      $display("FAIL write_read got %h expected %h", {rf_rd1, rf_rd2}, e);
    end
  endtask

  task automatic test_save;
    int writes = 0, done_at = 0;
    logic [31:0] e;
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hA000 + 16'(i));
    for (int i = 0; i < 8; i++) q.push_back({16'h00F0 + 16'(i), 16'hA000 + 16'(i)});
    ctx_save = 1;
    step;
    ctx_save = 0; rf_we = 1; rf_wa = 0; rf_wd = 16'hFFFF; rf_ra1 = 0;
    for (int c = 1; c <= 20 && done_at == 0; c++) begin
      #2;
      if (dm_we) begin
        writes++;
        e = q.size() > 0 ? q.pop_front() : 32'hFFFFFFFF;
        n_vec++;
        if ({dm_a, dm_id} !== e || !ctx_busy) begin
          n_err++;
          $display("FAIL save_write c=%0d got a/id=%h busy=%b expected %h busy=1", c, {dm_a, dm_id}, ctx_busy, e);
        end
        n_vec++;
        if (rf_rd1 !== 16'hA000) begin
          n_err++;
          $display("FAIL save_no_bypass got %h expected a000", rf_rd1);
        end
      end
      if (ctx_done) begin
        done_at = c;
        rf_we = 0;
      end
      step;
    end
    n_vec++;
    if (done_at != 9 || writes != 8 || q.size() != 0) begin
      n_err++;
      $display("FAIL save_count done_at=%0d writes=%0d left=%0d expected 9 8 0", done_at, writes, q.size());
    end
    q.delete();
    n_vec++;
    if (ctx_done !== 0 || ctx_busy !== 0 || rf_rd1 !== 16'hA000) begin
      n_err++;
      $display("FAIL save_after done=%b busy=%b reg0=%h expected 0 0 a000", ctx_done, ctx_busy, rf_rd1);
    end
  endtask

  task automatic test_restore;
    int we_seen = 0, done_at = 0;
    logic [31:0] e;
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h0000);
    for (int i = 0; i < 8; i++) mem[8'hF0 + 8'(i)] = 16'h5A00 + 16'(i);
    for (int i = 0; i < 8; i++) q.push_back({16'h00F0 + 16'(i), 16'h0});
    ctx_restore = 1;
    step;
    ctx_restore = 0;
    for (int c = 1; c <= 20 && done_at == 0; c++) begin
      #2;
      if (dm_we) we_seen++;
      if (ctx_busy) begin
        e = q.size() > 0 ? q.pop_front() : 32'hFFFFFFFF;
        n_vec++;
        if ({dm_a, 16'h0} !== e) begin
          n_err++;
          $display("FAIL restore_addr c=%0d got %h expected %h", c, dm_a, e[31:16]);
        end
      end
      if (ctx_done) done_at = c;
      step;
    end
    n_vec++;
    if (done_at != 9 || we_seen != 0) begin
      n_err++;
      $display("FAIL restore_seq done_at=%0d dm_we_cycles=%0d expected 9 0", done_at, we_seen);
    end
    q.delete();
    for (int i = 0; i < 8; i++) begin
      rf_ra1 = 3'(i); rf_ra2 = 3'(i);
      q.push_back({16'h5A00 + 16'(i), 16'h5A00 + 16'(i)});
      #1;
      e = q.pop_front();
      n_vec++;
      if ({rf_rd1, rf_rd2} !== e) begin
        n_err++;
        $display("FAIL restore_reg i=%0d got %h expected %h", i, {rf_rd1, rf_rd2}, e);
      end
    end
  endtask

  task automatic test_both_and_retrigger;
    int writes = 0, done_at = 0, busy_n = 0;
    logic [31:0] e;
    for (int i = 0; i < 8; i++) q.push_back({16'h00F0 + 16'(i), 16'h5A00 + 16'(i)});
    ctx_save = 1; ctx_restore = 1;
    step;
    ctx_save = 0; ctx_restore = 0;
    for (int c = 1; c <= 30 && done_at == 0; c++) begin
      #2;
      ctx_save = 0;
      if (ctx_busy) busy_n++;
      if (busy_n == 3 && ctx_busy) ctx_save = 1;
      if (dm_we) begin
        writes++;
        e = q.size() > 0 ? q.pop_front() : 32'hFFFFFFFF;
        n_vec++;
        if ({dm_a, dm_id} !== e) begin
          n_err++;
          $display("FAIL both_write c=%0d got %h expected %h", c, {dm_a, dm_id}, e);
        end
      end
      if (ctx_done) done_at = c;
      step;
    end
    ctx_save = 0;
    repeat (12) begin
      if (dm_we) writes++;
      step;
    end
    n_vec++;
    if (done_at != 9 || writes != 8 || ctx_busy !== 0) begin
      n_err++;
      $display("FAIL both_retrigger done_at=%0d writes=%0d busy=%b expected 9 8 0", done_at, writes, ctx_busy);
    end
    q.delete();
  endtask

  task automatic test_reset_mid_save;
    int busy_n = 0;
    ctx_save = 1;
    step;
    ctx_save = 0;
    for (int c = 1; c <= 20 && busy_n < 4; c++) begin
      #2;
      if (ctx_busy) busy_n++;
      if (busy_n == 4) begin
        reset = 1;
        rf_ra1 = 3; rf_ra2 = 7;
        #1;
        n_vec++;
        if ({dm_we, ctx_busy, dm_a} !== 18'h0 || {rf_rd1, rf_rd2} !== 32'h0) begin
          n_err++;
          $display("FAIL reset_mid_save we=%b busy=%b a=%h rd=%h expected 0 0 0000 00000000", dm_we, ctx_busy, dm_a, {rf_rd1, rf_rd2});
        end
      end else step;
    end
    n_vec++;
    if (busy_n != 4) begin
      n_err++;
      $display("FAIL reset_mid_save_reach busy_cycles=%0d expected 4", busy_n);
    end
    step;
    reset = 0;
    step;
  endtask

  task automatic test_bypass;
    rf_we = 1; rf_wa = 2; rf_wd = 16'h00FF; rf_ra1 = 2; rf_ra2 = 2;
    #1;
    n_vec++;
    if (rf_rd1 !== BYP_EXP || rf_rd2 !== BYP_EXP) begin
      n_err++;
      $display("FAIL same_cycle_read got %h/%h expected %h", rf_rd1, rf_rd2, BYP_EXP);
    end
    step;
    rf_we = 0;
    #1;
    n_vec++;
    if (rf_rd1 !== 16'h00FF) begin
      n_err++;
      $display("FAIL after_write_read got %h expected 00ff", rf_rd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset;
    test_write_read;
    test_save;
    test_restore;
    test_both_and_retrigger;
    test_reset_mid_save;
    test_bypass;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
